// File: rtl/ts_pkg.sv
// Shared constants, header field positions and state type for the MPEG-2 TS receive framer.
package ts_pkg;
  localparam int unsigned TS_DATA_W   = 8;
  localparam int unsigned TS_PID_W    = 13;
  localparam int unsigned TS_POS_W    = 8;
  localparam int unsigned TS_CNT_W    = 4;
  localparam int unsigned TS_CC_W     = 4;
  localparam int unsigned TS_ERRCNT_W = 16;

  localparam logic [TS_DATA_W-1:0] TS_SYNC_BYTE = 8'h47;
  localparam int unsigned          TS_PKT_LEN   = 188;
  localparam logic [TS_PID_W-1:0]  TS_NULL_PID  = 13'h1FFF;

  // Header byte positions and bit fields within them
  localparam int unsigned TS_POS_PID_HI = 1;
  localparam int unsigned TS_POS_PID_LO = 2;
  localparam int unsigned TS_POS_CC     = 3;
  localparam int unsigned TS_TEI_BIT    = 7;
  localparam int unsigned TS_PID_HI_MSB = 4;
  localparam int unsigned TS_AFC_MSB    = 5;
  localparam int unsigned TS_AFC_LSB    = 4;
  localparam int unsigned TS_CC_MSB     = 3;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} ts_state_e;
endpackage

// File: rtl/ts_packet_sync_if.sv
// Byte-stream input and framed-packet output bundle of the TS framer.
interface ts_packet_sync_if;
  import ts_pkg::*;

  logic                   valid;
  logic [TS_DATA_W-1:0]   byte_data;
  logic [TS_PID_W-1:0]    watch_pid;
  logic                   out_valid;
  logic [TS_DATA_W-1:0]   out_data;
  logic                   sop;
  logic                   eop;
  logic                   locked;
  logic [TS_PID_W-1:0]    pid;
  logic                   tei;
  logic                   sync_err;
  logic                   cc_err;
  logic [TS_ERRCNT_W-1:0] cc_err_cnt;

  modport master (
    output valid, byte_data, watch_pid,
    input  out_valid, out_data, sop, eop, locked, pid, tei, sync_err, cc_err, cc_err_cnt
  );

  modport slave (
    input  valid, byte_data, watch_pid,
    output out_valid, out_data, sop, eop, locked, pid, tei, sync_err, cc_err, cc_err_cnt
  );
endinterface

// File: rtl/ts_cc_checker.sv
// Continuity-counter check for one watched PID; flags CC jumps and keeps a saturating count.
module ts_cc_checker
  import ts_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   stb,
  input  logic                   clr,
  input  logic [TS_PID_W-1:0]    pid,
  input  logic [TS_PID_W-1:0]    watch_pid,
  input  logic [1:0]             afc,
  input  logic [TS_CC_W-1:0]     cc,
  output logic                   cc_err,
  output logic [TS_ERRCNT_W-1:0] cc_err_cnt
);
  logic                   cc_seen_q, cc_seen_d;
  logic [TS_CC_W-1:0]     last_cc_q, last_cc_d;
  logic                   cc_err_q, cc_err_d;
  logic [TS_ERRCNT_W-1:0] cnt_q, cnt_d;
  logic                   check_c, cont_c;
  logic                   unused_afc;

  assign unused_afc = afc[1];
  assign check_c = stb && (pid == watch_pid) && (watch_pid != TS_NULL_PID) && afc[0];
  // A repeated CC is a legal duplicate; otherwise it must advance by one
  assign cont_c  = (cc == last_cc_q) || (cc == TS_CC_W'(last_cc_q + 1'b1));

  always_comb begin
    cc_seen_d = cc_seen_q;
    last_cc_d = last_cc_q;
    cc_err_d  = 1'b0;
    cnt_d     = cnt_q;
    if (clr) begin
      cc_seen_d = 1'b0;
    end else if (check_c) begin
      cc_seen_d = 1'b1;
      last_cc_d = cc;
      if (cc_seen_q && !cont_c) begin
        cc_err_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cc_seen_q <= 1'b0;
      last_cc_q <= '0;
      cc_err_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cc_seen_q <= cc_seen_d;
      last_cc_q <= last_cc_d;
      cc_err_q  <= cc_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cc_err     = cc_err_q;
  assign cc_err_cnt = cnt_q;
endmodule

// File: rtl/ts_packet_sync.sv
// MPEG-2 TS sync acquisition, aligned packet forwarding and header parse.
// Define TS_CC_CHECK_EN to include continuity checking of watch_pid.
module ts_packet_sync
  import ts_pkg::*;
#(
  parameter int unsigned SYNC_LOCK  = 3,
  parameter int unsigned SYNC_LOSS  = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic             clk,
  input logic             rstn,
  ts_packet_sync_if.slave bus
);
  localparam logic [TS_POS_W-1:0] POS_LAST = TS_POS_W'(TS_PKT_LEN - 1);
  localparam logic [TS_CNT_W-1:0] LOCK_N   = TS_CNT_W'(SYNC_LOCK);
  localparam logic [TS_CNT_W-1:0] LOSS_N   = TS_CNT_W'(SYNC_LOSS);

  ts_state_e              state_q, state_d;
  logic [TS_POS_W-1:0]    pos_q, pos_d, pos_next_c;
  logic [TS_CNT_W-1:0]    hits_q, hits_d, miss_q, miss_d, hits_inc_c, miss_inc_c;
  logic                   out_valid_q, out_valid_d, sop_q, sop_d, eop_q, eop_d;
  logic                   locked_q, locked_d, sync_err_q, sync_err_d, tei_q, tei_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic [TS_PID_W-1:0]    pid_q, pid_d;
  logic                   is_sync_c, pos0_c, fwd_c;

  assign is_sync_c  = (bus.byte_data == TS_SYNC_BYTE);
  assign pos0_c     = (pos_q == '0);
  assign pos_next_c = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
  assign hits_inc_c = hits_q + 1'b1;
  assign miss_inc_c = miss_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= HUNT;
      pos_q   <= '0;
      hits_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      hits_q  <= hits_d;
      miss_q  <= miss_d;
    end
  end

  // Sync acquisition / loss; a failed verify byte is not reconsidered as a candidate
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    hits_d  = hits_q;
    miss_d  = miss_q;
    if (bus.valid) begin
      unique case (state_q)
        HUNT: begin
          if (is_sync_c) begin
            state_d = VERIFY;
            pos_d   = TS_POS_W'(1);
            hits_d  = TS_CNT_W'(1);
          end
        end
        VERIFY: begin
          pos_d = pos_next_c;
          if (pos0_c && !is_sync_c) begin
            state_d = HUNT;
            pos_d   = '0;
            hits_d  = '0;
          end else if (pos0_c) begin
            hits_d = hits_inc_c;
            if (hits_inc_c == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end
        end
        LOCKED: begin
          pos_d = pos_next_c;
          if (pos0_c && is_sync_c) begin
            miss_d = '0;
          end else if (pos0_c && (miss_inc_c == LOSS_N)) begin
            state_d = HUNT;
            pos_d   = '0;
            hits_d  = '0;
            miss_d  = '0;
          end else if (pos0_c) begin
            miss_d = miss_inc_c;
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
          hits_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // Forward while locked, including the locking sync byte and the byte that drops lock
  assign fwd_c = bus.valid && ((state_q == LOCKED) || (state_d == LOCKED));

  always_comb begin
    out_valid_d = fwd_c;
    out_data_d  = fwd_c ? bus.byte_data : out_data_q;
    sop_d       = fwd_c && pos0_c;
    eop_d       = fwd_c && (pos_q == POS_LAST);
    sync_err_d  = fwd_c && (state_q == LOCKED) && pos0_c && !is_sync_c;
    locked_d    = (state_d == LOCKED) || fwd_c;
    pid_d       = pid_q;
    tei_d       = tei_q;
    if (bus.valid && (state_q == LOCKED)) begin
      if (pos_q == TS_POS_W'(TS_POS_PID_HI)) begin
        tei_d                 = bus.byte_data[TS_TEI_BIT];
        pid_d[TS_PID_W-1:8]   = bus.byte_data[TS_PID_HI_MSB:0];
      end else if (pos_q == TS_POS_W'(TS_POS_PID_LO)) begin
        pid_d[7:0] = bus.byte_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      pid_q       <= '0;
      tei_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
      pid_q       <= pid_d;
      tei_q       <= tei_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sop       = sop_q;
  assign bus.eop       = eop_q;
  assign bus.locked    = locked_q;
  assign bus.sync_err  = sync_err_q;
  assign bus.pid       = pid_q;
  assign bus.tei       = tei_q;

`ifdef TS_CC_CHECK_EN
  logic cc_stb_c, cc_clr_c;

  assign cc_stb_c = bus.valid && (state_q == LOCKED) && (pos_q == TS_POS_W'(TS_POS_CC));
  assign cc_clr_c = (state_q == LOCKED) && (state_d == HUNT);

  ts_cc_checker u_cc_checker (
    .clk        (clk),
    .rstn       (rstn),
    .stb        (cc_stb_c),
    .clr        (cc_clr_c),
    .pid        (pid_q),
    .watch_pid  (bus.watch_pid),
    .afc        (bus.byte_data[TS_AFC_MSB:TS_AFC_LSB]),
    .cc         (bus.byte_data[TS_CC_MSB:0]),
    .cc_err     (bus.cc_err),
    .cc_err_cnt (bus.cc_err_cnt)
  );
`else
  logic unused_watch;

  assign unused_watch   = ^bus.watch_pid;
  assign bus.cc_err     = 1'b0;
  assign bus.cc_err_cnt = '0;
`endif
endmodule

// File: tb/tb_ts_packet_sync.sv
// Scoreboard bench for ts_packet_sync: a behavioural framer model predicts every output cycle.
module tb_ts_packet_sync;
  localparam int unsigned LOCK_N = 3;
  localparam int unsigned LOSS_N = 3;
  localparam logic [12:0] WATCH  = 13'h100;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;
`ifdef TS_CC_CHECK_EN
  localparam int CC_EXP = 1;
`else
  localparam int CC_EXP = 0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ts_packet_sync_if bus ();

  ts_packet_sync #(.SYNC_LOCK(LOCK_N), .SYNC_LOSS(LOSS_N), .DATA_WIDTH(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int          m_state, m_pos, m_hits, m_miss;
  logic [12:0] m_pid;
  logic        m_tei;
  logic [15:0] m_cnt;
`ifdef TS_CC_CHECK_EN
  logic        m_cc_seen;
  logic [3:0]  m_last_cc;
`endif

  logic [63:0] exp_q[$];
  logic [9:0]  fwd_log[$];
  logic [9:0]  log_a[$];
  int sop_n, eop_n, fwd_n, se_n, ce_n, in_idx, last_idx, first_fwd, pkt_seed;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic ov, input logic sp, input logic ep,
                                       input logic lk, input logic se, input logic ce,
                                       input logic [7:0] d, input logic [12:0] pid,
                                       input logic tei, input logic [15:0] cnt);
    return {20'h0, cnt, pid, tei, lk, se, ce, ep, sp, ov, (ov ? d : 8'h00)};
  endfunction

  function automatic logic [63:0] dut_outs();
    return pack(bus.out_valid, bus.sop, bus.eop, bus.locked, bus.sync_err, bus.cc_err,
                bus.out_data, bus.pid, bus.tei, bus.cc_err_cnt);
  endfunction

  task automatic model_reset();
    m_state = M_HUNT; m_pos = 0; m_hits = 0; m_miss = 0;
    m_pid = '0; m_tei = 1'b0; m_cnt = '0;
`ifdef TS_CC_CHECK_EN
    m_cc_seen = 1'b0; m_last_cc = '0;
`endif
  endtask

  // Predict the output cycle that follows accepting (v, b)
  task automatic model_step(input logic v, input logic [7:0] b);
    logic fwd, sp, ep, se, ce;
    int p;
    fwd = 1'b0; sp = 1'b0; ep = 1'b0; se = 1'b0; ce = 1'b0;
    p = m_pos;
    if (v) begin
      if (m_state == M_HUNT) begin
        if (b == 8'h47) begin m_state = M_VERIFY; m_pos = 1; m_hits = 1; end
      end else if (m_state == M_VERIFY) begin
        m_pos = (p + 1) % 188;
        if (p == 0 && b != 8'h47) begin
          m_state = M_HUNT; m_pos = 0; m_hits = 0;
        end else if (p == 0) begin
          m_hits++;
          if (m_hits == LOCK_N) begin m_state = M_LOCKED; m_miss = 0; fwd = 1'b1; end
        end
      end else begin
        fwd = 1'b1;
        m_pos = (p + 1) % 188;
        if (p == 0) begin
          if (b == 8'h47) m_miss = 0;
          else begin
            se = 1'b1;
            m_miss++;
            if (m_miss == LOSS_N) begin
              m_state = M_HUNT; m_pos = 0; m_miss = 0; m_hits = 0;
`ifdef TS_CC_CHECK_EN
              m_cc_seen = 1'b0;
`endif
            end
          end
        end
        if (p == 1) begin m_tei = b[7]; m_pid[12:8] = b[4:0]; end
        if (p == 2) m_pid[7:0] = b;
`ifdef TS_CC_CHECK_EN
        if (p == 3 && m_pid == WATCH && WATCH != 13'h1FFF && b[4]) begin
          if (m_cc_seen && b[3:0] != m_last_cc && b[3:0] != 4'(m_last_cc + 4'd1)) begin
            ce = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt++;
          end
          m_cc_seen = 1'b1;
          m_last_cc = b[3:0];
        end
`endif
      end
      sp = fwd && (p == 0);
      ep = fwd && (p == 187);
    end
    exp_q.push_back(pack(fwd, sp, ep, fwd || (m_state == M_LOCKED), se, ce, b, m_pid, m_tei, m_cnt));
  endtask

  task automatic sample();
    if (exp_q.size() != 0) check_eq("cyc", dut_outs(), exp_q.pop_front());
    if (bus.out_valid) begin
      fwd_n++;
      fwd_log.push_back({bus.sop, bus.eop, bus.out_data});
      if (first_fwd < 0) first_fwd = last_idx;
      if (bus.sop) sop_n++;
      if (bus.eop) eop_n++;
    end
    if (bus.sync_err) se_n++;
    if (bus.cc_err) ce_n++;
  endtask

  task automatic cycle(input logic v, input logic [7:0] b);
    @(negedge clk);
    sample();
    bus.valid     = v;
    bus.byte_data = v ? b : 8'h00;
    if (v) begin last_idx = in_idx; in_idx++; end
    model_step(v, b);
  endtask

  task automatic start_test();
    sop_n = 0; eop_n = 0; fwd_n = 0; se_n = 0; ce_n = 0;
    in_idx = 0; last_idx = 0; first_fwd = -1; pkt_seed = 0;
    fwd_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample();
    rstn = 1'b0; bus.valid = 1'b0; bus.byte_data = 8'h00;
    #1;
    check_eq("rst_outs", dut_outs(), 64'h0);
    check_eq("rst_data", 64'(bus.out_data), 64'h0);
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send_pkt(input logic [12:0] pid, input logic [3:0] cc, input logic [1:0] afc,
                          input logic tei, input logic [7:0] sync, input int gap_pct,
                          input int first, input int last);
    logic [7:0] b;
    for (int k = first; k <= last; k++) begin
      case (k)
        0:       b = sync;
        1:       b = {tei, 2'b00, pid[12:8]};
        2:       b = pid[7:0];
        3:       b = {2'b00, afc, cc};
        default: begin
          b = 8'(k * 13 + pkt_seed);
          if (b == 8'h47) b = 8'h48;
        end
      endcase
      if (int'($urandom_range(99)) < gap_pct) cycle(1'b0, 8'h00);
      cycle(1'b1, b);
    end
    pkt_seed++;
  endtask

  task automatic good_pkt(input logic [12:0] pid, input logic [3:0] cc, input int gap_pct);
    send_pkt(pid, cc, 2'b01, 1'b0, 8'h47, gap_pct, 0, 187);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ccs [6];
    ccs = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6};
    bus.valid = 1'b0; bus.byte_data = 8'h00; bus.watch_pid = WATCH;
    model_reset();
    start_test();

    // clean stream, continuous valid
    do_reset(); start_test();
    for (int i = 0; i < 10; i++) good_pkt(13'h011, 4'(i), 0);
    cycle(1'b0, 8'h00);
    check_eq("clean_sop", 64'(sop_n), 64'd8);
    check_eq("clean_eop", 64'(eop_n), 64'd8);
    check_eq("clean_bytes", 64'(fwd_n), 64'(8 * 188));
    check_eq("clean_first", 64'(first_fwd), 64'd376);
    log_a = fwd_log;

    // same stream with ~30% idle cycles
    do_reset(); start_test();
    for (int i = 0; i < 10; i++) good_pkt(13'h011, 4'(i), 30);
    cycle(1'b0, 8'h00);
    check_eq("gap_len", 64'(fwd_log.size()), 64'(log_a.size()));
    for (int i = 0; i < fwd_log.size() && i < log_a.size(); i++)
      check_eq("gap_byte", 64'(fwd_log[i]), 64'(log_a[i]));

    // false candidates at 50 and 300 ahead of the real grid at 400
    do_reset(); start_test();
    for (int i = 0; i < 400; i++) cycle(1'b1, (i == 50 || i == 300) ? 8'h47 : 8'h00);
    for (int i = 0; i < 5; i++) good_pkt(13'h022, 4'(i), 0);
    cycle(1'b0, 8'h00);
    check_eq("false_first", 64'(first_fwd), 64'd964);
    check_eq("false_sop", 64'(sop_n), 64'd2);

    // three bad syncs drop lock, then relock
    do_reset(); start_test();
    for (int i = 0; i < 12; i++)
      send_pkt(13'h033, 4'(i), 2'b01, 1'b0, (i >= 5 && i <= 7) ? 8'h00 : 8'h47, 0, 0, 187);
    cycle(1'b0, 8'h00);
    check_eq("loss_syncerr", 64'(se_n), 64'd3);
    check_eq("loss_sop", 64'(sop_n), 64'd8);

    // continuity sequence with one jump
    do_reset(); start_test();
    good_pkt(13'h200, 4'd0, 0); good_pkt(13'h200, 4'd1, 0);
    for (int i = 0; i < 6; i++)
      send_pkt(WATCH, ccs[i], 2'b01, (i == 2), 8'h47, 0, 0, 187);
    cycle(1'b0, 8'h00);
    check_eq("cc_pulses", 64'(ce_n), 64'(CC_EXP));
    check_eq("cc_count", 64'(bus.cc_err_cnt), 64'(CC_EXP));

    // payload-less packet carrying the jump is not checked
    do_reset(); start_test();
    good_pkt(13'h200, 4'd0, 0); good_pkt(13'h200, 4'd1, 0);
    for (int i = 0; i < 5; i++)
      send_pkt(WATCH, ccs[i], (i == 4) ? 2'b10 : 2'b01, 1'b0, 8'h47, 0, 0, 187);
    check_eq("cc_skip", 64'(ce_n), 64'd0);
    good_pkt(WATCH, 4'd6, 0);

    // reset mid-packet while locked
    send_pkt(WATCH, 4'd7, 2'b01, 1'b0, 8'h47, 0, 0, 99);
    do_reset(); start_test();
    send_pkt(WATCH, 4'd7, 2'b01, 1'b0, 8'h47, 0, 100, 187);
    cycle(1'b0, 8'h00);
    check_eq("rst_nofwd", 64'(fwd_n), 64'd0);
    for (int i = 0; i < 4; i++) good_pkt(13'h044, 4'(i), 0);
    cycle(1'b0, 8'h00);
    check_eq("rst_relock", 64'(sop_n), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ts_packet_sync.md
# ts_packet_sync

Receive-side framer for the MPEG-2 TS byte streams that the QoS datapath consumes: it takes one byte-wide `valid`/`byte_data` stream (one bench stimulus channel or one upstream tuner port) and acquires 0x47 sync at 188-byte spacing. Once locked, it forwards aligned packets with start/end markers and extracts the PID. It also checks the continuity counter of one watched PID, so packet loss in the incoming streams becomes visible as error pulses and a count.

## Interface
- `SYNC_LOCK`, default 3: number of consecutive syncs at 188-byte spacing needed to declare lock (range 2..15).
- `SYNC_LOSS`, default 3: number of consecutive missed syncs while locked that drops lock (range 1..15).
- `DATA_WIDTH`, default 8: byte width; fixed at 8.
- `clk` in 1: single clock; all logic on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `valid` in 1: `byte_data` is valid this cycle; gaps are allowed.
- `byte_data` in 8: TS byte.
- `watch_pid` in 13: PID under continuity check; quasi-static.
- `out_valid` out 1: forwarded byte valid.
- `out_data` out 8: forwarded byte.
- `sop` out 1: `out_data` is byte 0 of a packet.
- `eop` out 1: `out_data` is byte 187.
- `locked` out 1: state is LOCKED.
- `pid` out 13: PID of the current packet.
- `tei` out 1: transport_error_indicator of the current packet.
- `sync_err` out 1: pulse; the byte at packet position 0 was not 0x47 while locked.
- `cc_err` out 1: pulse; continuity discontinuity on `watch_pid`.
- `cc_err_cnt` out 16: saturating count of `cc_err` pulses.

## Operation
- Only cycles with `valid`=1 advance any state. `pos` is the byte position, 0..187; it wraps from 187 to 0.
- HUNT:
  - If the accepted byte is 0x47: go to VERIFY, set `pos`=1, `hits`=1.
  - Otherwise stay in HUNT.
- VERIFY:
  - Counts bytes. When `pos` reaches 0, check the byte.
  - If it is 0x47, increment `hits`. When `hits` reaches `SYNC_LOCK`, go to LOCKED. That sync byte is forwarded with `sop`.
  - If it is not 0x47, go to HUNT with `hits`=0. That byte is not re-examined as a new sync candidate.
- LOCKED:
  - Every accepted byte is forwarded.
  - At `pos`=0:
    - 0x47: clear `miss`.
    - Other value: forward the byte anyway with `sop`, pulse `sync_err`, increment `miss`.
    - When `miss` reaches `SYNC_LOSS`: go to HUNT and clear `cc_seen`. The failing byte is still forwarded. Bytes after it are not forwarded.
- Header parse, LOCKED only:
  - `pos`=1: `tei`=bit7; `pid[12:8]`=bits4:0.
  - `pos`=2: `pid[7:0]`=byte.
  - `pos`=3: `afc`=bits5:4; `cc`=bits3:0.
- Continuity check, evaluated at `pos`=3 when `pid`==`watch_pid`, `watch_pid`≠0x1FFF and `afc[0]`=1 (payload present):
  - If `cc_seen`=0: store `cc`, set `cc_seen`.
  - Otherwise, if `cc` is neither `last_cc` (one duplicate tolerated) nor (`last_cc`+1) mod 16: pulse `cc_err` and increment `cc_err_cnt`, which saturates at 0xFFFF.
  - In both cases store `cc` as `last_cc`.
  - Packets with `afc[0]`=0 are neither checked nor stored.

## Timing
- Reset values: all outputs 0; `pid`=0; state HUNT; `pos`, `hits`, `miss` all 0; `cc_seen`=0.
- Latency is 1 cycle, registered: `out_*`, `sop`, `eop` appear the cycle after the byte is accepted.
- `sync_err` is aligned with `sop` of its byte.
- `cc_err` is aligned with `out_valid` of byte 3.
- `pid` and `tei` update in the cycle after bytes 1/2 are accepted. They hold until the next packet.
- `locked` rises in the same cycle as the first forwarded `sop`. It falls the cycle after the last forwarded byte.
- All pulses are exactly one cycle wide. `out_valid`=0 in cycles after `valid`=0.
- `rstn` deasserted mid-packet is handled as the reset values above; no partial packet is emitted afterward.

## Configuration
- `TS_CC_CHECK_EN` defined: continuity checking as described.
- Undefined: the `last_cc`/`cc_seen`/counter logic is removed; `cc_err` is tied to 0 and `cc_err_cnt` to 0. Framing, `pid` and `tei` are unchanged.

## Structure
- Package `ts_pkg`:
  - `TS_SYNC_BYTE`=8'h47, `TS_PKT_LEN`=188, `TS_NULL_PID`=13'h1FFF.
  - State type {HUNT, VERIFY, LOCKED}.
  - Header field bit positions.
- One sub-module: `ts_cc_checker`. It takes the `pos`==3 strobe, `pid`, `afc` and `cc`, and produces `cc_err` and `cc_err_cnt`. It is instantiated only under `TS_CC_CHECK_EN`.

## Test plan
- Clean stream, 10 packets, `SYNC_LOCK`=3, continuous `valid` → `locked`=1 at the start of packet 3; exactly 8 `sop` and 8 `eop`; 1-cycle latency; `out_data` bit-exact.
- 0x47 at offsets 50 and 300 (spacing 250) before real alignment at 400 → false candidates return to HUNT; lock is acquired on the 400-based grid.
- Locked, then 3 consecutive packets with sync byte 0x00 → 3 `sync_err` pulses; `locked` falls after the third; the fourth packet is not forwarded; relock occurs after 3 good syncs.
- `watch_pid`=0x100, CC sequence 0,1,2,2,5,6 → one `cc_err` (at 5); `cc_err_cnt`=1. Same sequence with `afc`=2'b10 on the 5 → no error.
- Random `valid` gaps (≈30 % idle) on the clean stream → output identical to the gap-free run, apart from timing.
- `rstn` pulled low at `pos`=100 while locked → all outputs 0 on the next edge; HUNT; `cc_err_cnt`=0.
